// File: rtl/sock_line_ctrl_if.sv
// Operator-panel / loom signal bundle for the sock line controller.
// master drives commands and sensors; slave is the controller.
interface sock_line_ctrl_if #(
   parameter int NCH   = 5,
   parameter int CH_W  = 3,
   parameter int QTY_W = 4,
   parameter int CNT_W = 8
);
   logic             start;
   logic [CH_W-1:0]  sel;
   logic [QTY_W-1:0] qty;
   logic [NCH-1:0]   thread_ok;
   logic             knit_done;
   logic             insp_pass;
   logic             insp_fail;
   logic             abort;
   logic             ack;
   logic [CH_W-1:0]  rd_sel;
   logic [NCH-1:0]   motor_en;
   logic [2:0]       state_led;
   logic             busy;
   logic             batch_done;
   logic             bad_cmd;
   logic             fault;
   logic [QTY_W-1:0] remaining;
   logic [CNT_W-1:0] reject_cnt;
   logic [CNT_W-1:0] rd_total;

   modport master (
      output start, sel, qty, thread_ok, knit_done, insp_pass, insp_fail,
             abort, ack, rd_sel,
      input  motor_en, state_led, busy, batch_done, bad_cmd, fault,
             remaining, reject_cnt, rd_total
   );

   modport slave (
      input  start, sel, qty, thread_ok, knit_done, insp_pass, insp_fail,
             abort, ack, rd_sel,
      output motor_en, state_led, busy, batch_done, bad_cmd, fault,
             remaining, reject_cnt, rd_total
   );
endinterface

// File: rtl/sock_line_ctrl.sv
// Sock knitting line controller: NCH product channels, check/knit/inspect batch loop.
// Optional SOCK_REJECT_LIMIT_EN faults after MAX_REJ consecutive inspection rejects.
//
// state   | meaning
// IDLE    | waiting for a start command
// CHECK   | waiting for thread_ok on the selected channel (timed)
// KNIT    | loom motor of the selected channel running
// INSPECT | waiting for the inspection verdict
// DONE    | batch complete, batch_done asserted
// FAULT   | thread timeout or reject limit, waiting for ack
module sock_line_ctrl #(
   parameter int NCH     = 5,
   parameter int CH_W    = 3,
   parameter int QTY_W   = 4,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 16,
   parameter int MAX_REJ = 3
) (
   input  logic           clk,
   input  logic           reset,
   sock_line_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CHECK   = 3'd1,
      S_KNIT    = 3'd2,
      S_INSPECT = 3'd3,
      S_DONE    = 3'd4,
      S_FAULT   = 3'd5
   } state_t;

   localparam int              TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]   WAIT_LOAD = TW'(TIMEOUT - 1);
   localparam logic [CH_W:0]   NCH_L     = (CH_W + 1)'(NCH);

   state_t           state, state_nx;
   logic [CH_W-1:0]  ch;
   logic [QTY_W-1:0] remaining;
   logic [TW-1:0]    wait_cnt;
   logic [CNT_W-1:0] total [NCH];
   logic [CNT_W-1:0] reject_cnt;
   logic             bad_cmd;
   logic [NCH-1:0]   motor_en;
   logic [CNT_W-1:0] rd_total;

   logic cmd_ok, thr_sel, limit_hit;
   logic latch_cmd, bad_nx, pass_ev, fail_ev, clr_rem;

   assign cmd_ok = ({1'b0, bus.sel} < NCH_L) && (bus.qty != '0);

   always_comb begin
      thr_sel = 1'b0;
      for (int i = 0; i < NCH; i++)
         if (ch == CH_W'(i)) thr_sel = bus.thread_ok[i];
   end

`ifdef SOCK_REJECT_LIMIT_EN
   localparam int RW = $clog2(MAX_REJ + 1);
   logic [RW-1:0] rej_run;

   // this reject is the one that brings the run up to MAX_REJ
   assign limit_hit = (rej_run >= RW'(MAX_REJ - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rej_run <= '0;
      end else if (state_nx == S_IDLE || pass_ev) begin
         rej_run <= '0;
      end else if (fail_ev && rej_run != '1) begin
         rej_run <= rej_run + 1'b1;
      end
   end
`else
   // rejects are unlimited in this build
   assign limit_hit = (MAX_REJ < 0);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      latch_cmd = 1'b0;
      bad_nx    = 1'b0;
      pass_ev   = 1'b0;
      fail_ev   = 1'b0;
      clr_rem   = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               if (cmd_ok) begin
                  latch_cmd = 1'b1;
                  state_nx  = S_CHECK;
               end else begin
                  bad_nx = 1'b1;
               end
            end
         end
         S_CHECK: begin
            if (thr_sel)              state_nx = S_KNIT;
            else if (wait_cnt == '0)  state_nx = S_FAULT;
         end
         S_KNIT: begin
            if (bus.knit_done) state_nx = S_INSPECT;
         end
         S_INSPECT: begin
            if (bus.insp_fail) begin
               fail_ev  = 1'b1;
               state_nx = limit_hit ? S_FAULT : S_CHECK;
            end else if (bus.insp_pass) begin
               pass_ev  = 1'b1;
               state_nx = (remaining == QTY_W'(1)) ? S_DONE : S_CHECK;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         S_FAULT: begin
            if (bus.ack) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      if (state_nx == S_FAULT && state != S_FAULT) clr_rem = 1'b1;
      // abort overrides any decision made above, including inspection counting
      if (bus.abort && state != S_IDLE && state != S_FAULT) begin
         state_nx = S_IDLE;
         pass_ev  = 1'b0;
         fail_ev  = 1'b0;
         clr_rem  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ch         <= '0;
         remaining  <= '0;
         wait_cnt   <= WAIT_LOAD;
         reject_cnt <= '0;
         bad_cmd    <= 1'b0;
         for (int i = 0; i < NCH; i++) total[i] <= '0;
      end else begin
         bad_cmd <= bad_nx;
         if (latch_cmd) begin
            ch        <= bus.sel;
            remaining <= bus.qty;
         end else if (clr_rem) begin
            remaining <= '0;
         end else if (pass_ev && remaining != '0) begin
            remaining <= remaining - 1'b1;
         end
         // down-counter runs only while CHECK waits; reloaded everywhere else
         if (state == S_CHECK && !thr_sel) begin
            if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
         end else begin
            wait_cnt <= WAIT_LOAD;
         end
         if (fail_ev && reject_cnt != '1) reject_cnt <= reject_cnt + 1'b1;
         for (int i = 0; i < NCH; i++)
            if (pass_ev && ch == CH_W'(i) && total[i] != '1)
               total[i] <= total[i] + 1'b1;
      end
   end

   always_comb begin
      motor_en = '0;
      rd_total = '0;
      for (int i = 0; i < NCH; i++) begin
         if (state == S_KNIT && ch == CH_W'(i)) motor_en[i] = 1'b1;
         if (bus.rd_sel == CH_W'(i))            rd_total    = total[i];
      end
   end

   assign bus.motor_en   = motor_en;
   assign bus.state_led  = state;
   assign bus.busy       = (state != S_IDLE);
   assign bus.batch_done = (state == S_DONE);
   assign bus.bad_cmd    = bad_cmd;
   assign bus.fault      = (state == S_FAULT);
   assign bus.remaining  = remaining;
   assign bus.reject_cnt = reject_cnt;
   assign bus.rd_total   = rd_total;

endmodule
